// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, ALU codes,
// opcodes, datapath select codes and the registered control-word layout.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SHR = 3'b111;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_RDATA   = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       op7b5;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    localparam ctrl_t CTRL_FETCH = '{
        alu_ctrl:   ALU_ADD,
        op7b5:      1'b0,
        alu_src_a:  SRC_A_PC,
        alu_src_b:  SRC_B_FOUR,
        result_src: RES_ALU,
        adr_src:    1'b0,
        ir_write:   1'b1,
        pc_write:   1'b1,
        reg_write:  1'b0,
        mem_write:  1'b0
    };

    // R-type has no immediate; it falls through to the I encoding.
    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational funct3/funct7 decode into an ALU operation; SUB only exists for R-type.
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl,
    output logic       op7b5
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        op7b5    = 1'b0;
        case (funct3)
            3'b000: alu_ctrl = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_ctrl = ALU_SLL;
            3'b010: alu_ctrl = ALU_SLT;
            3'b011: alu_ctrl = ALU_SLT;
            3'b100: alu_ctrl = ALU_XOR;
            3'b101: begin
                alu_ctrl = ALU_SHR;
                op7b5    = funct7b5;
            end
            3'b110: alu_ctrl = ALU_OR;
            3'b111: alu_ctrl = ALU_AND;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM. The control word is registered alongside the state;
// only the branch pc_write, illegal and imm_src are decoded combinationally.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [2:0] alu_ctrl,
    output logic       op7b5,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [2:0] dec_alu_ctrl;
    logic       dec_op7b5;
    logic       is_rtype;
    logic       branch_taken;

    // The decoder looks at the state being entered so its result lands in ctrl_q.
    assign is_rtype = (state_d == S_EXECR);

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .is_rtype (is_rtype),
        .alu_ctrl (dec_alu_ctrl),
        .op7b5    (dec_op7b5)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        ctrl_d = CTRL_IDLE;
        case (state_d)
            S_FETCH: ctrl_d = CTRL_FETCH;
            S_DECODE: begin
                ctrl_d.alu_src_a = SRC_A_OLDPC;
                ctrl_d.alu_src_b = SRC_B_IMM;
            end
            S_MEMADR: begin
                ctrl_d.alu_src_a = SRC_A_RS1;
                ctrl_d.alu_src_b = SRC_B_IMM;
            end
            S_MEMREAD: begin
                ctrl_d.result_src = RES_ALUOUT;
                ctrl_d.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_d.result_src = RES_RDATA;
                ctrl_d.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_d.result_src = RES_ALUOUT;
                ctrl_d.adr_src    = 1'b1;
                ctrl_d.mem_write  = 1'b1;
            end
            S_EXECR: begin
                ctrl_d.alu_src_a = SRC_A_RS1;
                ctrl_d.alu_src_b = SRC_B_RS2;
                ctrl_d.alu_ctrl  = dec_alu_ctrl;
                ctrl_d.op7b5     = dec_op7b5;
            end
            S_EXECI: begin
                ctrl_d.alu_src_a = SRC_A_RS1;
                ctrl_d.alu_src_b = SRC_B_IMM;
                ctrl_d.alu_ctrl  = dec_alu_ctrl;
                ctrl_d.op7b5     = dec_op7b5;
            end
            S_ALUWB: begin
                ctrl_d.result_src = RES_ALUOUT;
                ctrl_d.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a  = SRC_A_RS1;
                ctrl_d.alu_src_b  = SRC_B_RS2;
                ctrl_d.alu_ctrl   = ALU_SUB;
                ctrl_d.result_src = RES_ALUOUT;
            end
            S_JAL: begin
                ctrl_d.alu_src_a  = SRC_A_OLDPC;
                ctrl_d.alu_src_b  = SRC_B_FOUR;
                ctrl_d.result_src = RES_ALUOUT;
                ctrl_d.pc_write   = 1'b1;
            end
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    // Reset parks the control word at FETCH so the first edge after release fetches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= CTRL_FETCH;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = ~zero;
            default: branch_taken = 1'b0;
        endcase
    end

    // Everything is forced low while reset is held, including the parked FETCH word.
    always_comb begin
        alu_ctrl   = ALU_ADD;
        op7b5      = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            alu_ctrl   = ctrl_q.alu_ctrl;
            op7b5      = ctrl_q.op7b5;
            alu_src_a  = ctrl_q.alu_src_a;
            alu_src_b  = ctrl_q.alu_src_b;
            result_src = ctrl_q.result_src;
            imm_src    = imm_decode(op);
            adr_src    = ctrl_q.adr_src;
            ir_write   = ctrl_q.ir_write;
            pc_write   = ctrl_q.pc_write | ((state_q == S_BRANCH) & branch_taken);
            reg_write  = ctrl_q.reg_write;
            mem_write  = ctrl_q.mem_write;
            illegal    = (state_q == S_DECODE) & ~is_legal(op);
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected state and control word queues.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [2:0] alu_ctrl;
    logic       op7b5;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  exp_st_q[$];
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .alu_ctrl   (alu_ctrl),
        .op7b5      (op7b5),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word layout: illegal, alu_ctrl, op7b5, a, b, result_src, adr, ir, pc, reg, mem.
    function automatic logic [15:0] mk(input logic ill, input logic [2:0] alu, input logic o7,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res, input logic adr, input logic ir,
                                       input logic pc, input logic rw, input logic mw);
        return {ill, alu, o7, a, b, res, adr, ir, pc, rw, mw};
    endfunction

    function automatic logic [15:0] sig_now();
        return {illegal, alu_ctrl, op7b5, alu_src_a, alu_src_b, result_src,
                adr_src, ir_write, pc_write, reg_write, mem_write};
    endfunction

    localparam logic [15:0] E_FETCH   = {1'b0, 3'b000, 1'b0, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic [15:0] E_DECODE  = {1'b0, 3'b000, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_ILLDEC  = {1'b1, 3'b000, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMADR  = {1'b0, 3'b000, 1'b0, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMREAD = {1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [15:0] E_MEMWB   = {1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] E_MEMWR   = {1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [15:0] E_ALUWB   = {1'b0, 3'b000, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] E_JAL     = {1'b0, 3'b000, 1'b0, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic [15:0] e_execr(input logic [2:0] alu, input logic o7);
        return mk(1'b0, alu, o7, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [15:0] e_execi(input logic [2:0] alu, input logic o7);
        return mk(1'b0, alu, o7, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [15:0] e_branch(input logic pcw);
        return mk(1'b0, 3'b001, 1'b0, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, pcw, 1'b0, 1'b0);
    endfunction

    task automatic expect_cycle(input logic [3:0] st, input logic [15:0] sg);
        exp_st_q.push_back(st);
        exp_q.push_back(sg);
    endtask

    // Called just after a rising edge; consumes one queued cycle per clock.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic [1:0] exp_imm);
        int cyc;
        logic [3:0]  st;
        logic [15:0] sg;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        cyc = 0;
        while (exp_st_q.size() > 0) begin
            @(negedge clk);
            st = exp_st_q.pop_front();
            sg = exp_q.pop_front();
            check($sformatf("%s c%0d state", tag, cyc), {28'd0, state_dbg}, {28'd0, st});
            check($sformatf("%s c%0d ctrl", tag, cyc), {16'd0, sig_now()}, {16'd0, sg});
            if (cyc == 1)
                check($sformatf("%s imm_src", tag), {30'd0, imm_src}, {30'd0, exp_imm});
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b1; op = OP_STORE; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        @(negedge clk);
        check("reset state", {28'd0, state_dbg}, 32'd0);
        check("reset ctrl", {16'd0, sig_now()}, 32'd0);
        check("reset imm", {30'd0, imm_src}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd6, e_execr(3'b000, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("add", 7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd6, e_execr(3'b001, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("sub", 7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd7, e_execi(3'b111, 1'b1)); expect_cycle(4'd8, E_ALUWB);
        run_instr("srai", 7'b0010011, 3'b101, 1'b1, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd7, e_execi(3'b000, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("addi_f7b5", 7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd6, e_execr(3'b111, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("srl", 7'b0110011, 3'b101, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd6, e_execr(3'b011, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("or", 7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd7, e_execi(3'b010, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd6, e_execr(3'b101, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("sltu", 7'b0110011, 3'b011, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd7, e_execi(3'b110, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("slli", 7'b0010011, 3'b001, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd6, e_execr(3'b100, 1'b0)); expect_cycle(4'd8, E_ALUWB);
        run_instr("xor", 7'b0110011, 3'b100, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd2, E_MEMADR); expect_cycle(4'd3, E_MEMREAD);
        expect_cycle(4'd4, E_MEMWB);
        run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd2, E_MEMADR); expect_cycle(4'd5, E_MEMWR);
        run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE); expect_cycle(4'd9, e_branch(1'b1));
        run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10);
        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE); expect_cycle(4'd9, e_branch(1'b0));
        run_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10);
        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE); expect_cycle(4'd9, e_branch(1'b1));
        run_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 2'b10);
        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE); expect_cycle(4'd9, e_branch(1'b0));
        run_instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 2'b10);
        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE); expect_cycle(4'd9, e_branch(1'b0));
        run_instr("blt_z1", 7'b1100011, 3'b100, 1'b0, 1'b1, 2'b10);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd10, E_JAL); expect_cycle(4'd8, E_ALUWB);
        run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 2'b11);

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_ILLDEC);
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 2'b00);

        // Reset lands in the middle of MEMADR of a load.
        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00);
        check("abort pre state", {28'd0, state_dbg}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("abort state", {28'd0, state_dbg}, 32'd0);
        check("abort ctrl", {16'd0, sig_now()}, 32'd0);
        @(posedge clk);
        #1;
        check("abort held state", {28'd0, state_dbg}, 32'd0);
        check("abort held ctrl", {16'd0, sig_now()}, 32'd0);
        reset = 1'b0;

        expect_cycle(4'd0, E_FETCH); expect_cycle(4'd1, E_DECODE);
        expect_cycle(4'd2, E_MEMADR); expect_cycle(4'd3, E_MEMREAD);
        expect_cycle(4'd4, E_MEMWB);
        run_instr("lw_after", 7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00);

        @(negedge clk);
        check("end state", {28'd0, state_dbg}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
